// File: rtl/vx_reorder_queue_pkg.sv
// rtl/vx_reorder_queue_pkg.sv - shared sizing helper for the reorder queue
package vx_reorder_queue_pkg;

  // Width needed to index n items; never narrower than one bit.
  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_reorder_queue_dp_ram.sv
// rtl/vx_reorder_queue_dp_ram.sv - completion payload store, one write port, one async read port
module vx_reorder_queue_dp_ram #(
  parameter int DATAW = 32,
  parameter int SIZE  = 8,
  parameter int ADDRW = 3
) (
  input  logic             clk,
  input  logic             write,
  input  logic [ADDRW-1:0] waddr,
  input  logic [DATAW-1:0] wdata,
  input  logic [ADDRW-1:0] raddr,
  output logic [DATAW-1:0] rdata
);

  logic [DATAW-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (write) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vx_reorder_queue.sv
// rtl/vx_reorder_queue.sv - tag-based completion buffer that retires out-of-order fills in allocation order
module vx_reorder_queue
  import vx_reorder_queue_pkg::*;
#(
  parameter  int DATAW = 32,
  parameter  int SIZE  = 8,
  localparam int ADDRW = log2up(SIZE),
  localparam int CNTW  = log2up(SIZE + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  output logic [ADDRW-1:0] alloc_tag,
  input  logic             fill_valid,
  input  logic [ADDRW-1:0] fill_tag,
  input  logic [DATAW-1:0] fill_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ADDRW-1:0] rsp_tag,
  output logic [DATAW-1:0] rsp_data,
  output logic [CNTW-1:0]  count
);

  logic [ADDRW:0]   rd_ptr, wr_ptr;
  logic [SIZE-1:0]  done, done_n;
  logic [ADDRW-1:0] rd_a, wr_a;
  logic             empty, full;
  logic             alloc_fire, retire_fire;

  assign rd_a  = rd_ptr[ADDRW-1:0];
  assign wr_a  = wr_ptr[ADDRW-1:0];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_a == rd_a) && (wr_ptr[ADDRW] != rd_ptr[ADDRW]);

  assign alloc_ready = !full;
  assign alloc_tag   = wr_a;
  assign rsp_valid   = !empty && done[rd_a];
  assign rsp_tag     = rd_a;
  assign count       = CNTW'(wr_ptr - rd_ptr);

  assign alloc_fire  = alloc_valid && alloc_ready;
  assign retire_fire = rsp_valid && rsp_ready;

  // Under legal use the three events hit distinct tags, so their order here is immaterial.
  always_comb begin
    done_n = done;
    if (retire_fire) done_n[rd_a] = 1'b0;
    if (fill_valid)  done_n[fill_tag] = 1'b1;
    if (alloc_fire)  done_n[wr_a] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      done   <= '0;
    end else begin
      done <= done_n;
      if (alloc_fire)  wr_ptr <= wr_ptr + 1'b1;
      if (retire_fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  vx_reorder_queue_dp_ram #(
    .DATAW (DATAW),
    .SIZE  (SIZE),
    .ADDRW (ADDRW)
  ) u_store (
    .clk   (clk),
    .write (fill_valid),
    .waddr (fill_tag),
    .wdata (fill_data),
    .raddr (rd_a),
    .rdata (rsp_data)
  );

`ifndef SYNTHESIS
  // A tag is outstanding when its distance from the head is below the occupancy.
  logic [ADDRW-1:0] fill_off;
  assign fill_off = fill_tag - rd_a;

  always_ff @(posedge clk) begin
    if (reset && fill_valid) begin
      assert ((CNTW'(fill_off) < count) && !done[fill_tag])
        else $error("vx_reorder_queue: fill to unallocated or completed tag %0d", fill_tag);
    end
  end
`endif

endmodule

// File: tb/tb_vx_reorder_queue.sv
// tb/tb_vx_reorder_queue.sv - scoreboard bench for vx_reorder_queue
module tb_vx_reorder_queue;

  localparam int DATAW = 8;
  localparam int SIZE  = 4;
  localparam int AW    = 2;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             alloc_valid;
  logic             alloc_ready;
  logic [AW-1:0]    alloc_tag;
  logic             fill_valid;
  logic [AW-1:0]    fill_tag;
  logic [DATAW-1:0] fill_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [AW-1:0]    rsp_tag;
  logic [DATAW-1:0] rsp_data;
  logic [CW-1:0]    count;

  always #5 clk = ~clk;

  vx_reorder_queue #(
    .DATAW (DATAW),
    .SIZE  (SIZE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .alloc_valid (alloc_valid),
    .alloc_ready (alloc_ready),
    .alloc_tag   (alloc_tag),
    .fill_valid  (fill_valid),
    .fill_tag    (fill_tag),
    .fill_data   (fill_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_tag     (rsp_tag),
    .rsp_data    (rsp_data),
    .count       (count)
  );

  int checks = 0;
  int errors = 0;

  int               m_wr, m_rd;
  logic [DATAW-1:0] m_data [SIZE];
  bit               m_done [SIZE];
  int               exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_wr = 0;
    m_rd = 0;
    exp_q.delete();
    for (int i = 0; i < SIZE; i++) m_done[i] = 1'b0;
  endtask

  // Compare the current cycle against the model, then commit this cycle's events.
  task automatic evaluate();
    int m_cnt;
    bit exp_rv;
    m_cnt  = m_wr - m_rd;
    exp_rv = (exp_q.size() > 0) && m_done[exp_q[0]];
    check_eq("count", 32'(count), 32'(m_cnt));
    check_eq("alloc_ready", 32'(alloc_ready), 32'(m_cnt < SIZE));
    check_eq("alloc_tag", 32'(alloc_tag), 32'(m_wr % SIZE));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      check_eq("rsp_tag", 32'(rsp_tag), 32'(exp_q[0]));
      check_eq("rsp_data", 32'(rsp_data), 32'(m_data[exp_q[0]]));
    end
    if (alloc_valid && m_cnt < SIZE) begin
      exp_q.push_back(m_wr % SIZE);
      m_wr++;
    end
    if (exp_rv && rsp_ready) begin
      m_done[exp_q[0]] = 1'b0;
      void'(exp_q.pop_front());
      m_rd++;
    end
    if (fill_valid) begin
      m_data[fill_tag] = fill_data;
      m_done[fill_tag] = 1'b1;
    end
  endtask

  task automatic drive(input bit av, input bit fv, input int ft, input int fd, input bit rr);
    alloc_valid = av;
    fill_valid  = fv;
    fill_tag    = AW'(ft);
    fill_data   = DATAW'(fd);
    rsp_ready   = rr;
  endtask

  task automatic step(input bit av, input bit fv, input int ft, input int fd, input bit rr);
    drive(av, fv, ft, fd, rr);
    @(negedge clk);
    evaluate();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, SIZE - 1),
            $urandom_range(0, 255), $urandom_range(0, 1) == 1);
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 0, 0);
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    check_eq("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check_eq("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pend [$];
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    do_reset();

    // In-order single
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 'hA1, 0);
    step(0, 0, 0, 0, 1);
    step(0, 1, 1, 'hB1, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Out-of-order completion, head last
    do_reset();
    repeat (4) step(1, 0, 0, 0, 0);
    step(0, 1, 3, 'hD3, 1);
    step(0, 1, 1, 'hD1, 1);
    step(0, 1, 2, 'hD2, 1);
    step(0, 1, 0, 'hD0, 1);
    repeat (4) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Full, retire one, second lap reuses tag 0
    repeat (4) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 'hE0, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 'hE1, 1);
    step(0, 1, 2, 'hE2, 1);
    step(0, 1, 3, 'hE3, 1);
    step(0, 1, 0, 'hF0, 1);
    repeat (4) step(0, 0, 0, 0, 1);

    // Backpressure holds the head stable
    do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 'h5A, 0);
    step(0, 1, 1, 'h77, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Alloc, fill and retire in the same cycle
    do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 'hC0, 0);
    step(1, 1, 1, 'hC1, 1);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check_eq("sim_count", 32'(count), 32'd2);
    check_eq("sim_rsp_tag", 32'(rsp_tag), 32'd1);
    check_eq("sim_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("sim_alloc_tag", 32'(alloc_tag), 32'd3);
    evaluate();
    @(posedge clk);
    #1;
    step(0, 1, 2, 'hC2, 1);
    repeat (3) step(0, 0, 0, 0, 1);

    // Random legal traffic
    for (int n = 0; n < 300; n++) begin
      bit fv;
      int ft;
      pend.delete();
      foreach (exp_q[i]) if (!m_done[exp_q[i]]) pend.push_back(exp_q[i]);
      fv = (pend.size() > 0) && ($urandom_range(0, 2) != 0);
      ft = fv ? pend[$urandom_range(0, pend.size() - 1)] : 0;
      step($urandom_range(0, 1) == 1, fv, ft, $urandom_range(0, 255), $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
